// File: rtl/nmr_pulsers_pkg.sv
// Shared definitions for the spin-echo pulse-sequence generator.
// - state_e        : sequencer state encoding
// - PH90_LSB etc.  : bit positions inside the tx_phase control word
// - next_live()    : skips states whose latched duration is zero
package nmr_pulsers_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLead90,
        StP90,
        StGap1,
        StP180,
        StGap2,
        StAcq,
        StDone
    } state_e;

    localparam int unsigned PH90_LSB           = 0;
    localparam int unsigned PH180_LSB          = 2;
    localparam int unsigned REPEAT_BIT         = 4;
    localparam int unsigned DEFAULT_BLANK_LEAD = 4;

    // Starting from candidate state s, walk forward past every state whose duration is zero.
    // The checks are ordered so one pass follows a whole chain of skipped states.
    function automatic state_e next_live(state_e s, logic z90, logic zgap, logic z180,
                                         logic zrec);
        state_e r;
        r = s;
        if (r == StP90  && z90)  r = StGap1;
        if (r == StGap1 && zgap) r = StP180;
        if (r == StP180 && z180) r = StGap2;
        if (r == StGap2 && zgap) r = StAcq;
        if (r == StAcq  && zrec) r = StDone;
        return r;
    endfunction

endpackage

// File: rtl/nmr_pulsers_pulse_timer.sv
// Prescaled duration timer, restarted on every sequencer state entry.
// One tick lasts scale_i+1 clk cycles; done_o marks the last clk cycle of tick number dur_i.
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   load_i         restart prescaler and tick counter from zero next cycle
//   scale_i        prescale value (tick = scale_i+1 cycles)
//   dur_i          duration of the current state in ticks (must be non-zero when used)
//   done_o         current cycle is the final cycle of the duration
//   cnt_nxt_o      tick count the counter will hold next cycle
//   pre_nxt_o      prescaler value the counter will hold next cycle
module nmr_pulsers_pulse_timer #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [15:0]      scale_i,
    input  logic [CNT_W-1:0] dur_i,
    output logic             done_o,
    output logic [CNT_W-1:0] cnt_nxt_o,
    output logic [15:0]      pre_nxt_o
);

    logic [15:0]      pre_q, pre_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_end;

    always_comb begin
        tick_end = (pre_q == scale_i);
        done_o   = tick_end && (cnt_q == dur_i - CNT_W'(1));
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        if (load_i) begin
            pre_d = '0;
            cnt_d = '0;
        end else if (tick_end) begin
            pre_d = '0;
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            pre_d = pre_q + 16'd1;
        end
        cnt_nxt_o = cnt_d;
        pre_nxt_o = pre_d;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pre_q <= '0;
            cnt_q <= '0;
        end else begin
            pre_q <= pre_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/nmr_pulsers.sv
// Spin-echo pulse-sequence generator: unblank lead, 90 deg pulse, tau, 180 deg pulse, tau,
// acquisition window. All outputs are registered and line up with the state they belong to.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   enable               run request (level); dropping it aborts to IDLE
//   tx_phase             [1:0] 90 deg phase, [3:2] 180 deg phase, [4] continuous repeat
//   pulse_gap            tau in gap ticks
//   record_len           acquisition length in gap ticks
//   period90, period180  pulse lengths in pulse ticks
//   time_scale_factors   [31:16] pulse prescale, [15:0] gap prescale
//   tx, tx_val           TX DDS phase select and pulse valid
//   rx                   RX capture gate
//   u_blank              power-amplifier unblank
module nmr_pulsers
    import nmr_pulsers_pkg::*;
#(
    parameter int unsigned BLANK_LEAD = DEFAULT_BLANK_LEAD,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [4:0]       tx_phase,
    input  logic [CNT_W-1:0] pulse_gap,
    input  logic [CNT_W-1:0] record_len,
    input  logic [CNT_W-1:0] period90,
    input  logic [CNT_W-1:0] period180,
    input  logic [31:0]      time_scale_factors,
    output logic [1:0]       tx,
    output logic             tx_val,
    output logic             rx,
    output logic             u_blank
);

    state_e state_q, state_d;

    // Timing words captured at sequence start
    logic [4:0]       ph_q, ph_d;
    logic [CNT_W-1:0] gap_q, gap_d, rec_q, rec_d, p90_q, p90_d, p180_q, p180_d;
    logic [31:0]      scale_q, scale_d;

    logic [1:0] tx_q, tx_d;
    logic       tx_val_q, tx_val_d, rx_q, rx_d, u_blank_q, u_blank_d;

    logic             start;
    logic             t_load, t_done;
    logic [15:0]      t_scale, t_pre_nxt;
    logic [CNT_W-1:0] t_dur, t_cnt_nxt;
    logic [15:0]      pscale, gscale;

    logic [CNT_W-1:0] gap_left;
    logic [16:0]      span, tick_left;
    logic [33:0]      rem;
    logic             gap_tail;

    assign pscale = scale_q[31:16];
    assign gscale = scale_q[15:0];

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (state_q != StIdle && !enable) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (enable) state_d = StLead90;
                StLead90: if (t_done) state_d = next_live(StP90, p90_q == '0, gap_q == '0,
                                                          p180_q == '0, rec_q == '0);
                StP90:    if (t_done) state_d = next_live(StGap1, p90_q == '0, gap_q == '0,
                                                          p180_q == '0, rec_q == '0);
                StGap1:   if (t_done) state_d = next_live(StP180, p90_q == '0, gap_q == '0,
                                                          p180_q == '0, rec_q == '0);
                StP180:   if (t_done) state_d = next_live(StGap2, p90_q == '0, gap_q == '0,
                                                          p180_q == '0, rec_q == '0);
                StGap2:   if (t_done) state_d = next_live(StAcq, p90_q == '0, gap_q == '0,
                                                          p180_q == '0, rec_q == '0);
                StAcq:    if (t_done) state_d = StDone;
                // enable is known high here; single shot parks until it drops
                StDone:   if (ph_q[REPEAT_BIT]) state_d = StLead90;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Entering LEAD90 from IDLE or DONE (re)captures the timing words
    assign start = (state_d == StLead90) && (state_q != StLead90);

    always_comb begin
        ph_d    = ph_q;
        gap_d   = gap_q;
        rec_d   = rec_q;
        p90_d   = p90_q;
        p180_d  = p180_q;
        scale_d = scale_q;
        if (start) begin
            ph_d    = tx_phase;
            gap_d   = pulse_gap;
            rec_d   = record_len;
            p90_d   = period90;
            p180_d  = period180;
            scale_d = time_scale_factors;
        end
    end

    // Timer setup for the state currently being timed
    always_comb begin
        t_scale = 16'd0;
        t_dur   = '0;
        case (state_q)
            StLead90: t_dur = CNT_W'(BLANK_LEAD);
            StP90:    begin t_scale = pscale; t_dur = p90_q;  end
            StGap1:   begin t_scale = gscale; t_dur = gap_q;  end
            StP180:   begin t_scale = pscale; t_dur = p180_q; end
            StGap2:   begin t_scale = gscale; t_dur = gap_q;  end
            StAcq:    begin t_scale = gscale; t_dur = rec_q;  end
            default:  ;
        endcase
    end

    assign t_load = (state_d != state_q) || (state_d == StIdle) || (state_d == StDone);

    nmr_pulsers_pulse_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (t_load),
        .scale_i   (t_scale),
        .dur_i     (t_dur),
        .done_o    (t_done),
        .cnt_nxt_o (t_cnt_nxt),
        .pre_nxt_o (t_pre_nxt)
    );

    // Raw clk cycles left in GAP1 as seen next cycle, compared against BLANK_LEAD.
    // Whole ticks left is checked first so the multiply only needs a narrow operand.
    always_comb begin
        gap_left  = gap_q - CNT_W'(1) - t_cnt_nxt;
        span      = {1'b0, gscale} + 17'd1;
        tick_left = span - {1'b0, t_pre_nxt};
        rem       = 34'(gap_left[15:0]) * 34'(span) + 34'(tick_left);
        gap_tail  = (gap_left < CNT_W'(BLANK_LEAD)) && (rem <= 34'(BLANK_LEAD));
    end

    // Outputs decoded from the upcoming state so they coincide with it
    always_comb begin
        tx_val_d  = (state_d == StP90) || (state_d == StP180);
        tx_d      = 2'b00;
        if (state_d == StP90)  tx_d = ph_d[PH90_LSB +: 2];
        if (state_d == StP180) tx_d = ph_d[PH180_LSB +: 2];
        rx_d      = (state_d == StAcq);
        u_blank_d = (state_d == StLead90) || tx_val_d || ((state_d == StGap1) && gap_tail);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            ph_q      <= '0;
            gap_q     <= '0;
            rec_q     <= '0;
            p90_q     <= '0;
            p180_q    <= '0;
            scale_q   <= '0;
            tx_q      <= 2'b00;
            tx_val_q  <= 1'b0;
            rx_q      <= 1'b0;
            u_blank_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            gap_q     <= gap_d;
            rec_q     <= rec_d;
            p90_q     <= p90_d;
            p180_q    <= p180_d;
            scale_q   <= scale_d;
            tx_q      <= tx_d;
            tx_val_q  <= tx_val_d;
            rx_q      <= rx_d;
            u_blank_q <= u_blank_d;
        end
    end

    assign tx      = tx_q;
    assign tx_val  = tx_val_q;
    assign rx      = rx_q;
    assign u_blank = u_blank_q;

endmodule

// File: tb/tb_nmr_pulsers.sv
// Scoreboard bench for nmr_pulsers: an interval model of the pulse sequence predicts
// {tx_val, tx, rx, u_blank} for every cycle; the prediction is queued after each clock edge
// and popped and compared on the following falling edge.
module tb_nmr_pulsers;

    localparam int unsigned BL = 4;

    logic        clk = 1'b0;
    logic        rst, enable;
    logic [4:0]  tx_phase;
    logic [31:0] pulse_gap, record_len, period90, period180, time_scale_factors;
    logic [1:0]  tx;
    logic        tx_val, rx, u_blank;

    always #5 clk = ~clk;

    nmr_pulsers #(
        .BLANK_LEAD (BL),
        .CNT_W      (32)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .enable             (enable),
        .tx_phase           (tx_phase),
        .pulse_gap          (pulse_gap),
        .record_len         (record_len),
        .period90           (period90),
        .period180          (period180),
        .time_scale_factors (time_scale_factors),
        .tx                 (tx),
        .tx_val             (tx_val),
        .rx                 (rx),
        .u_blank            (u_blank)
    );

    typedef struct {
        logic [4:0] vec;
        int         cyc;
    } exp_t;

    exp_t  sb_q[$];
    exp_t  sb_e;
    int    n_vec = 0;
    int    n_err = 0;
    string test_name = "init";
    int    cyc = 0;

    // Model: offset m_k into the sequence; m_k == m_tot means DONE
    bit         m_act = 1'b0;
    longint     m_k = 0;
    longint     m_tot = 0;
    longint     m_seg[6];
    logic [4:0] m_ph = '0;

    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: {tx_val,tx,rx,u_blank} got %b want %b", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            sb_e = sb_q.pop_front();
            check($sformatf("%s@%0d", test_name, sb_e.cyc), {tx_val, tx, rx, u_blank}, sb_e.vec);
        end
    end

    function automatic longint seq_len();
        longint p, g;
        p = longint'(time_scale_factors[31:16]) + 1;
        g = longint'(time_scale_factors[15:0]) + 1;
        return longint'(BL) + longint'(period90) * p + 2 * longint'(pulse_gap) * g +
               longint'(period180) * p + longint'(record_len) * g;
    endfunction

    task automatic model_latch();
        longint p, g;
        p        = longint'(time_scale_factors[31:16]) + 1;
        g        = longint'(time_scale_factors[15:0]) + 1;
        m_ph     = tx_phase;
        m_seg[0] = longint'(BL);
        m_seg[1] = longint'(period90) * p;
        m_seg[2] = longint'(pulse_gap) * g;
        m_seg[3] = longint'(period180) * p;
        m_seg[4] = longint'(pulse_gap) * g;
        m_seg[5] = longint'(record_len) * g;
        m_tot    = seq_len();
        m_k      = 0;
    endtask

    task automatic model_step();
        if (rst) begin
            m_act = 1'b0;
        end else if (!m_act) begin
            if (enable) begin
                model_latch();
                m_act = 1'b1;
            end
        end else if (!enable) begin
            m_act = 1'b0;
        end else if (m_k < m_tot) begin
            m_k++;
        end else if (m_ph[4]) begin
            model_latch();
        end
    endtask

    function automatic logic [4:0] model_out();
        longint s;
        if (!m_act || m_k >= m_tot) return 5'b00000;
        s = 0;
        if (m_k < s + m_seg[0]) return 5'b00001;
        s += m_seg[0];
        if (m_k < s + m_seg[1]) return {1'b1, m_ph[1:0], 2'b01};
        s += m_seg[1];
        if (m_k < s + m_seg[2]) return {4'b0000, m_k >= s + m_seg[2] - longint'(BL)};
        s += m_seg[2];
        if (m_k < s + m_seg[3]) return {1'b1, m_ph[3:2], 2'b01};
        s += m_seg[3];
        if (m_k < s + m_seg[4]) return 5'b00000;
        return 5'b00010;
    endfunction

    task automatic tick();
        exp_t e;
        @(posedge clk);
        model_step();
        e.vec = model_out();
        e.cyc = cyc;
        sb_q.push_back(e);
        cyc++;
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_seq(input int extra);
        run(int'(seq_len()) + 1 + extra);
    endtask

    task automatic new_test(input string name);
        test_name = name;
        cyc       = 1;
    endtask

    task automatic set_cfg(input logic [4:0] ph, input logic [31:0] gap, input logic [31:0] rec,
                           input logic [31:0] p90, input logic [31:0] p180,
                           input logic [31:0] ts);
        tx_phase           = ph;
        pulse_gap          = gap;
        record_len         = rec;
        period90           = p90;
        period180          = p180;
        time_scale_factors = ts;
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        set_cfg(5'd9, 200, 400, 50, 100, 32'd0);
        new_test("reset");
        run(3);

        // Nominal sequence, then park in DONE while enable stays high
        rst = 1'b0;
        new_test("nominal");
        enable = 1'b1;
        run_seq(6);
        enable = 1'b0;
        run(2);

        new_test("pscale1");
        set_cfg(5'd9, 200, 400, 50, 100, {16'd1, 16'd0});
        enable = 1'b1;
        run_seq(3);
        enable = 1'b0;
        run(2);

        new_test("gscale3");
        set_cfg(5'd9, 200, 400, 50, 100, {16'd0, 16'd3});
        enable = 1'b1;
        run_seq(3);
        enable = 1'b0;
        run(2);

        new_test("repeat");
        set_cfg(5'b11001, 200, 400, 50, 100, 32'd0);
        enable = 1'b1;
        run(2 * 955 + 30);
        enable = 1'b0;
        run(2);

        // Abort in the middle of P180, then a fresh start
        new_test("abort");
        set_cfg(5'd9, 200, 400, 50, 100, 32'd0);
        enable = 1'b1;
        run(4 + 50 + 200 + 30);
        enable = 1'b0;
        run(3);
        enable = 1'b1;
        run(30);
        enable = 1'b0;
        run(2);

        new_test("zero_len");
        set_cfg(5'd9, 0, 400, 50, 0, 32'd0);
        enable = 1'b1;
        run_seq(4);
        enable = 1'b0;
        run(2);

        // GAP1 shorter than the unblank lead keeps u_blank high throughout
        new_test("short_gap");
        set_cfg(5'b00110, 2, 3, 3, 2, 32'd0);
        enable = 1'b1;
        run_seq(3);
        enable = 1'b0;
        run(2);

        // Mid-run input change must be ignored; reset during ACQ
        new_test("rst_acq");
        set_cfg(5'd9, 200, 400, 50, 100, 32'd0);
        enable = 1'b1;
        run(300);
        record_len = 10;
        run(300);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(40);
        enable = 1'b0;
        run(2);

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
